// File: rtl/midi_defs.sv
// Shared MIDI definitions: status byte constants, parser state encoding and
// the data-byte count helper used by the message parser.
package midi_defs;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 7;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] MTC_QF      = 8'hF1;
  localparam logic [7:0] SONG_POS    = 8'hF2;
  localparam logic [7:0] SONG_SEL    = 8'hF3;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_CLOCK    = 8'hF8;
  localparam logic [7:0] UNDEF_F9    = 8'hF9;
  localparam logic [7:0] UNDEF_FD    = 8'hFD;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_D1 = 2'd1;
  localparam logic [1:0] ST_WAIT_D2 = 2'd2;
  localparam logic [1:0] ST_SYSEX   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WAIT_D1 = ST_WAIT_D1,
    WAIT_D2 = ST_WAIT_D2,
    SYSEX   = ST_SYSEX
  } state_t;

  // Number of data bytes that follow a (non-realtime) status byte.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'hC, 4'hD:                   len = 2'd1;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hF: begin
        case (status)
          MTC_QF, SONG_SEL: len = 2'd1;
          SONG_POS:         len = 2'd2;
          default:          len = 2'd0;
        endcase
      end
      default:                      len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, interleaved realtime, SysEx streaming.
// Optional partial-message timeout is built when MIDI_PARSER_TIMEOUT_EN is defined.
module midi_msg_parser
  import midi_defs::*;
#(
  parameter int unsigned CLOCK        = 12_000_000,
  parameter int unsigned TIMEOUT_CLKS = CLOCK / 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxdv,
  input  logic [BYTE_W-1:0]   rxdata,
  output logic                msg_valid,
  output logic [BYTE_W-1:0]   msg_status,
  output logic [DATA_W-1:0]   msg_data1,
  output logic [DATA_W-1:0]   msg_data2,
  output logic [1:0]          msg_len,
  output logic                rt_valid,
  output logic [BYTE_W-1:0]   rt_byte,
  output logic                sysex_valid,
  output logic [BYTE_W-1:0]   sysex_byte,
  output logic                sysex_last,
  output logic                err
);

  state_t              state, state_d;
  logic [BYTE_W-1:0]   cur_status, cur_status_d;
  logic [1:0]          need_len, need_len_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic                partial, partial_d;

  logic                msg_valid_d;
  logic [BYTE_W-1:0]   msg_status_d;
  logic [DATA_W-1:0]   msg_data1_d, msg_data2_d;
  logic [1:0]          msg_len_d;
  logic                rt_valid_d;
  logic [BYTE_W-1:0]   rt_byte_d;
  logic                sysex_valid_d;
  logic [BYTE_W-1:0]   sysex_byte_d;
  logic                sysex_last_d;
  logic                err_d;

  logic is_rt, is_data, is_status;
  logic timeout_hit;

  assign is_rt     = rxdv && (rxdata >= RT_CLOCK);
  assign is_data   = rxdv && !rxdata[7];
  assign is_status = rxdv && rxdata[7] && (rxdata < RT_CLOCK);

`ifdef MIDI_PARSER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_armed;

  assign timeout_armed = (state == SYSEX) || (state == WAIT_D2) ||
                         ((state == WAIT_D1) && partial);
  assign timeout_hit   = timeout_armed && !is_data && !is_status &&
                         (idle_cnt == CNT_W'(TIMEOUT_CLKS - 1));

  // Idle counter: realtime bytes do not count as activity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (!timeout_armed || is_data || is_status || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CLKS);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    cur_status_d  = cur_status;
    need_len_d    = need_len;
    d1_d          = d1_q;
    partial_d     = partial;
    msg_valid_d   = 1'b0;
    msg_status_d  = msg_status;
    msg_data1_d   = msg_data1;
    msg_data2_d   = msg_data2;
    msg_len_d     = msg_len;
    rt_valid_d    = 1'b0;
    rt_byte_d     = rt_byte;
    sysex_valid_d = 1'b0;
    sysex_byte_d  = sysex_byte;
    sysex_last_d  = sysex_last;
    err_d         = 1'b0;

    if (is_rt) begin
      if (rxdata == UNDEF_F9 || rxdata == UNDEF_FD) begin
        err_d = 1'b1;
      end else begin
        rt_valid_d = 1'b1;
        rt_byte_d  = rxdata;
      end
    end

    if (is_data) begin
      case (state)
        IDLE: err_d = 1'b1;
        WAIT_D1: begin
          if (need_len == 2'd1) begin
            msg_valid_d  = 1'b1;
            msg_status_d = cur_status;
            msg_data1_d  = rxdata[DATA_W-1:0];
            msg_data2_d  = '0;
            msg_len_d    = 2'd1;
            partial_d    = 1'b0;
            state_d      = (cur_status[7:4] == 4'hF) ? IDLE : WAIT_D1;
          end else begin
            d1_d      = rxdata[DATA_W-1:0];
            partial_d = 1'b1;
            state_d   = WAIT_D2;
          end
        end
        WAIT_D2: begin
          msg_valid_d  = 1'b1;
          msg_status_d = cur_status;
          msg_data1_d  = d1_q;
          msg_data2_d  = rxdata[DATA_W-1:0];
          msg_len_d    = 2'd2;
          partial_d    = 1'b0;
          state_d      = (cur_status[7:4] == 4'hF) ? IDLE : WAIT_D1;
        end
        SYSEX: begin
          sysex_valid_d = 1'b1;
          sysex_byte_d  = rxdata;
          sysex_last_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end else if (is_status) begin
      if (state == SYSEX && rxdata == SYSEX_END) begin
        sysex_valid_d = 1'b1;
        sysex_byte_d  = SYSEX_END;
        sysex_last_d  = 1'b1;
        state_d       = IDLE;
      end else begin
        // Close out whatever was in flight before handling the new status.
        if (state == SYSEX) begin
          sysex_valid_d = 1'b1;
          sysex_byte_d  = SYSEX_END;
          sysex_last_d  = 1'b1;
          err_d         = 1'b1;
        end else if (state == WAIT_D2 || (state == WAIT_D1 && partial)) begin
          err_d = 1'b1;
        end
        partial_d = 1'b0;

        if (rxdata[7:4] != 4'hF) begin
          cur_status_d = rxdata;
          need_len_d   = midi_data_len(rxdata);
          partial_d    = 1'b1;
          state_d      = WAIT_D1;
        end else begin
          case (rxdata)
            // F0 inside SysEx: the stream slot carries the synthetic F7, so the
            // new opener is not forwarded; following bytes still stream.
            SYSEX_START: begin
              if (state != SYSEX) begin
                sysex_valid_d = 1'b1;
                sysex_byte_d  = SYSEX_START;
                sysex_last_d  = 1'b0;
              end
              state_d = SYSEX;
            end
            MTC_QF, SONG_POS, SONG_SEL: begin
              cur_status_d = rxdata;
              need_len_d   = midi_data_len(rxdata);
              partial_d    = 1'b1;
              state_d      = WAIT_D1;
            end
            TUNE_REQ: begin
              msg_valid_d  = 1'b1;
              msg_status_d = TUNE_REQ;
              msg_data1_d  = '0;
              msg_data2_d  = '0;
              msg_len_d    = 2'd0;
              state_d      = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
    end else if (timeout_hit) begin
      err_d = 1'b1;
      if (state == SYSEX) begin
        sysex_valid_d = 1'b1;
        sysex_byte_d  = SYSEX_END;
        sysex_last_d  = 1'b1;
      end
      partial_d = 1'b0;
      state_d   = IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cur_status  <= '0;
      need_len    <= 2'd0;
      d1_q        <= '0;
      partial     <= 1'b0;
      msg_valid   <= 1'b0;
      msg_status  <= '0;
      msg_data1   <= '0;
      msg_data2   <= '0;
      msg_len     <= 2'd0;
      rt_valid    <= 1'b0;
      rt_byte     <= '0;
      sysex_valid <= 1'b0;
      sysex_byte  <= '0;
      sysex_last  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      cur_status  <= cur_status_d;
      need_len    <= need_len_d;
      d1_q        <= d1_d;
      partial     <= partial_d;
      msg_valid   <= msg_valid_d;
      msg_status  <= msg_status_d;
      msg_data1   <= msg_data1_d;
      msg_data2   <= msg_data2_d;
      msg_len     <= msg_len_d;
      rt_valid    <= rt_valid_d;
      rt_byte     <= rt_byte_d;
      sysex_valid <= sysex_valid_d;
      sysex_byte  <= sysex_byte_d;
      sysex_last  <= sysex_last_d;
      err         <= err_d;
    end
  end

endmodule
